fxp_div_sm: RTL and testbench
=============================

Name: fxp_div_sm

Overview:
- Iterative divider for the 16-bit sign-magnitude fixed-point format used by the autoencoder datapath.
- Format: bit 15 is the sign; bits 14:0 are the magnitude with FRAC_W fractional bits.
- It is the inverse of the datapath multiplier and is used for normalisation and scaling steps such as mean and learning-rate division.
- Restoring radix-2 algorithm, one quotient bit per clock, with a start/busy/done handshake.

Parameters:
- DATA_W, 16: total word width including the sign bit.
- FRAC_W, 8: fractional bits of the magnitude.
- ITER = DATA_W-1+FRAC_W (23 by default, derived and not overridable): quotient bits produced.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while ready=1.
- Operand_1  input  DATA_W  dividend, sign-magnitude.
- Operand_2  input  DATA_W  divisor, sign-magnitude.
- ready  output  1  high in IDLE; start is accepted.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when result is updated.
- result  output  DATA_W  quotient, sign-magnitude; held until the next done.
- div_by_zero  output  1  set with done when divisor magnitude = 0.
- overflow  output  1  set with done when the quotient magnitude saturated.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - result=0, done=0, div_by_zero=0, overflow=0, busy=0, ready=1.
  - Internal registers are cleared.
  - Reset mid-operation aborts the division; no done is produced.
- States: IDLE, CALC, FIN.
- IDLE:
  - ready=1, busy=0.
  - On a clock edge with start=1, the block latches:
    - sign = Operand_1[15]^Operand_2[15].
    - Dividend register D = {Operand_1[14:0], FRAC_W zeros} (ITER bits).
    - Divisor magnitude M = Operand_2[14:0].
    - Partial remainder R = 0; iteration counter = 0.
  - If M=0: go to FIN with a divide-by-zero pending.
  - Otherwise: go to CALC.
- CALC (busy=1, ready=0):
  - Each cycle: R' = {R, D msb}; shift D left.
  - If R' >= M: R = R'-M and quotient bit = 1. Otherwise R = R' and quotient bit = 0.
  - The quotient bit is shifted into Q (ITER bits).
  - After ITER cycles, go to FIN.
  - R needs DATA_W bits to avoid losing the carry.
- FIN (busy=1): one cycle that registers the outputs, then goes to IDLE.
  - Divide-by-zero: result = {sign, all-ones magnitude}, div_by_zero=1, overflow=0.
  - Otherwise, if Q[ITER-1:DATA_W-1] ≠ 0: result = {sign, 15'h7FFF}, overflow=1.
  - Otherwise: result = {sign, Q[14:0]}.
  - Truncation is toward zero (floor of the magnitude); there is no rounding.
  - done=1 for exactly the cycle after the FIN edge.
  - Flags hold until the next done. They are cleared at the next accepted start.
- Latency:
  - start sampled at edge E0.
  - Normal result: result/done are valid after edge E(ITER+1) = E24.
  - Divide-by-zero: valid after E1.
  - Back-to-back operation: start may be asserted in the same cycle that done is high (ready=1); the next division is accepted at that edge.
- start while busy is ignored, with no queuing. Operand changes during CALC have no effect.
- Sign is always the XOR of the operand signs, including for a zero quotient. A negative-zero result (0x8000) is legal.
- A dividend of negative zero behaves as zero.

Test Plan:
- 0x0180 (1.5) / 0x0080 (0.5), start at E0 → result=0x0300, done pulse after E24 only, overflow=0, div_by_zero=0; busy high E0..E24.
- 0x8300 (-3.0) / 0x0200 (2.0) → 0x8180 (-1.5). Also 0x0100/0x0300 → 0x0055 (1/3 truncated: 65536/768=85).
- 0x0100 / 0x8000 (negative-zero divisor) → result=0xFFFF, div_by_zero=1, done after E1, busy for one cycle only.
- 0x7F00 (127.0) / 0x0010 (0.0625) → result=0x7FFF, overflow=1. Also 0x0000/0x0100 → 0x0000 with no flags.
- start pulsed with different operands at E5 during a division → ignored, first result is unchanged. start held high continuously → divisions are accepted at each done cycle, with one result every 25 cycles.
- Assert rst_n=0 at E10 of a division → all outputs go to reset values immediately, asynchronously. No done appears after rst_n returns high. The next start computes correctly.

Source files
------------

// File: rtl/fxp_div_sm_if.sv
`default_nettype none
// ============================================================================
// Module      : fxp_div_sm_if
// Description : Handshake and operand/result bundle for the sign-magnitude
//               fixed-point divider.
//               master : drives start, Operand_1, Operand_2; observes status
//               slave  : the divider; drives ready, busy, done, result, flags
// Revision    : 1.0 - initial release
// ============================================================================
interface fxp_div_sm_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic [DATA_W-1:0] Operand_1;
    logic [DATA_W-1:0] Operand_2;
    logic              ready;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              div_by_zero;
    logic              overflow;

    modport master (
        output start, Operand_1, Operand_2,
        input  ready, busy, done, result, div_by_zero, overflow
    );

    modport slave (
        input  start, Operand_1, Operand_2,
        output ready, busy, done, result, div_by_zero, overflow
    );
endinterface
`default_nettype wire

// File: rtl/fxp_div_sm.sv
`default_nettype none
// ============================================================================
// Module      : fxp_div_sm
// Description : Iterative restoring radix-2 divider for sign-magnitude
//               fixed-point words (sign in MSB, magnitude with FRAC_W
//               fractional bits). One quotient bit per clock.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - fxp_div_sm_if.slave: start/Operand_1/Operand_2 in;
//                       ready/busy/done/result/div_by_zero/overflow out
// Revision    : 1.0 - initial release
// ============================================================================
module fxp_div_sm #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  wire          clk,
    input  wire          rst_n,
    fxp_div_sm_if.slave  bus
);
    localparam int ITER  = DATA_W - 1 + FRAC_W;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam int MAG_W = DATA_W - 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIN  = 2'd2;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(ITER - 1);

    logic [1:0]        r_state;
    logic              r_sign;
    logic [ITER-1:0]   r_dvd;       // dividend, shifted out MSB first
    logic [MAG_W-1:0]  r_dvs;       // divisor magnitude
    logic [DATA_W-1:0] r_rem;       // partial remainder
    logic [ITER-1:0]   r_quo;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_dbz_pend;
    logic              r_done;
    logic [DATA_W-1:0] r_result;
    logic              r_div_by_zero;
    logic              r_overflow;

    logic [DATA_W-1:0] w_rem_shift;
    logic              w_qbit;
    logic [DATA_W-1:0] w_rem_next;
    logic              w_ovf;
    logic              w_unused;

    // The remainder after a step is always below the divisor, so its top bit
    // never carries information into the next shift.
    assign w_unused    = r_rem[DATA_W-1];

    assign w_rem_shift = {r_rem[DATA_W-2:0], r_dvd[ITER-1]};
    assign w_qbit      = (w_rem_shift >= {1'b0, r_dvs});
    assign w_rem_next  = w_qbit ? (w_rem_shift - {1'b0, r_dvs}) : w_rem_shift;

    // Any quotient bit above the magnitude field means saturation.
    assign w_ovf       = |r_quo[ITER-1:MAG_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_sign        <= 1'b0;
            r_dvd         <= '0;
            r_dvs         <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_cnt         <= '0;
            r_dbz_pend    <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_sign        <= bus.Operand_1[DATA_W-1] ^ bus.Operand_2[DATA_W-1];
                        r_dvd         <= {bus.Operand_1[MAG_W-1:0], {FRAC_W{1'b0}}};
                        r_dvs         <= bus.Operand_2[MAG_W-1:0];
                        r_rem         <= '0;
                        r_quo         <= '0;
                        r_cnt         <= '0;
                        r_div_by_zero <= 1'b0;
                        r_overflow    <= 1'b0;
                        if (bus.Operand_2[MAG_W-1:0] == '0) begin
                            r_dbz_pend <= 1'b1;
                            r_state    <= c_FIN;
                        end else begin
                            r_dbz_pend <= 1'b0;
                            r_state    <= c_CALC;
                        end
                    end
                end
                c_CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= {r_dvd[ITER-2:0], 1'b0};
                    r_quo <= {r_quo[ITER-2:0], w_qbit};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= c_FIN;
                    end
                end
                c_FIN: begin
                    r_done <= 1'b1;
                    if (r_dbz_pend) begin
                        r_result      <= {r_sign, {MAG_W{1'b1}}};
                        r_div_by_zero <= 1'b1;
                        r_overflow    <= 1'b0;
                    end else if (w_ovf) begin
                        r_result      <= {r_sign, {MAG_W{1'b1}}};
                        r_div_by_zero <= 1'b0;
                        r_overflow    <= 1'b1;
                    end else begin
                        r_result      <= {r_sign, r_quo[MAG_W-1:0]};
                        r_div_by_zero <= 1'b0;
                        r_overflow    <= 1'b0;
                    end
                    r_dbz_pend <= 1'b0;
                    r_state    <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.ready       = (r_state == c_IDLE);
    assign bus.busy        = (r_state != c_IDLE);
    assign bus.done        = r_done;
    assign bus.result      = r_result;
    assign bus.div_by_zero = r_div_by_zero;
    assign bus.overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fxp_div_sm.sv
`default_nettype none
// ============================================================================
// Module      : tb_fxp_div_sm
// Description : Directed self-checking bench for fxp_div_sm using
//               hand-computed quotients, flags and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fxp_div_sm;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    fxp_div_sm_if #(.DATA_W(16)) bus ();

    fxp_div_sm #(
        .DATA_W (16),
        .FRAC_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one start (accepted at edge E0) and waits up to 40 edges for done.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output logic dbz,
                           output logic ovf, output int lat, output logic busy0);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.Operand_1 = a;
        bus.Operand_2 = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy0 = bus.busy;
        res   = 16'h0;
        dbz   = 1'b0;
        ovf   = 1'b0;
        lat   = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                res = bus.result;
                dbz = bus.div_by_zero;
                ovf = bus.overflow;
                break;
            end
        end
    endtask

    task automatic div_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_res, input logic exp_dbz,
                           input logic exp_ovf, input int exp_lat);
        logic [15:0] res;
        logic        dbz;
        logic        ovf;
        int          lat;
        logic        busy0;
        run_div(a, b, res, dbz, ovf, lat, busy0);
        check({tag, " busy after start"}, 32'(busy0), 32'd1);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, 32'(res), 32'(exp_res));
        check({tag, " div_by_zero"}, 32'(dbz), 32'(exp_dbz));
        check({tag, " overflow"}, 32'(ovf), 32'(exp_ovf));
        check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
        check({tag, " ready at done"}, 32'(bus.ready), 32'd1);
        @(posedge clk);
        #1;
        check({tag, " done one cycle"}, 32'(bus.done), 32'd0);
        check({tag, " result held"}, 32'(bus.result), 32'(exp_res));
    endtask

    initial begin
        int t1;
        int t2;
        int done_seen;
        n_checks      = 0;
        n_fails       = 0;
        bus.start     = 1'b0;
        bus.Operand_1 = 16'h0;
        bus.Operand_2 = 16'h0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 32'(bus.ready), 32'd1);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset result", 32'(bus.result), 32'd0);
        check("reset dbz", 32'(bus.div_by_zero), 32'd0);
        check("reset ovf", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        div_vec("1.5/0.5",   16'h0180, 16'h0080, 16'h0300, 1'b0, 1'b0, 24);
        div_vec("-3/2",      16'h8300, 16'h0200, 16'h8180, 1'b0, 1'b0, 24);
        div_vec("1/3",       16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 24);
        div_vec("div -0",    16'h0100, 16'h8000, 16'hFFFF, 1'b1, 1'b0, 1);
        div_vec("div +0",    16'h8100, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1);
        div_vec("127/0.0625", 16'h7F00, 16'h0010, 16'h7FFF, 1'b0, 1'b1, 24);
        div_vec("0/1",       16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b0, 24);
        div_vec("-0/1",      16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, 24);

        // start pulsed mid-division with different operands must be ignored
        @(negedge clk);
        bus.start     = 1'b1;
        bus.Operand_1 = 16'h0180;
        bus.Operand_2 = 16'h0080;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.Operand_1 = 16'h7F00;
        bus.Operand_2 = 16'h0010;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        t1 = -1;
        for (int k = 6; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                t1 = k;
                break;
            end
        end
        check("ignore latency", t1, 24);
        check("ignore result", 32'(bus.result), 32'h0300);
        check("ignore ovf", 32'(bus.overflow), 32'd0);
        @(posedge clk);
        #1;
        check("ignore no 2nd op", 32'(bus.busy), 32'd0);

        // start held high: one result every 25 cycles
        @(negedge clk);
        bus.start     = 1'b1;
        bus.Operand_1 = 16'h0300;
        bus.Operand_2 = 16'h0200;
        @(posedge clk);
        t1 = -1;
        t2 = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                if (t1 < 0) begin
                    t1 = k;
                    check("b2b result 1", 32'(bus.result), 32'h0180);
                end else begin
                    t2 = k;
                    bus.start = 1'b0;
                    check("b2b result 2", 32'(bus.result), 32'h0180);
                    break;
                end
            end
        end
        check("b2b first latency", t1, 24);
        check("b2b period", t2 - t1, 25);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("b2b idle after", 32'(bus.ready), 32'd1);

        // asynchronous reset mid-division
        @(negedge clk);
        bus.start     = 1'b1;
        bus.Operand_1 = 16'h0100;
        bus.Operand_2 = 16'h0300;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst result", 32'(bus.result), 32'd0);
        check("arst busy", 32'(bus.busy), 32'd0);
        check("arst ready", 32'(bus.ready), 32'd1);
        check("arst done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen++;
        end
        check("arst no done", done_seen, 0);
        div_vec("post-reset 1.5/0.5", 16'h0180, 16'h0080, 16'h0300, 1'b0, 1'b0, 24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire
